dmio_arbiter: RTL and testbench

Two-port arbiter that shares the single data-memory/IO port (4096×64 RAM at address bit 12 = 0, LED register / switch input at bit 12 = 1) between the processor core (port A) and the program loader / debug engine (port B). It latches one request at a time, drives the memory port for exactly one cycle, and returns read data with a one-cycle acknowledge pulse. Alternating requests are served round-robin. Port B is prevented from reaching the IO region.

---
 rtl/dmio_arbiter.sv | 121 ++++++++++++
 tb/tb_dmio_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dmio_arbiter.sv
// rtl/dmio_arbiter.sv - two-port round-robin arbiter for the shared data-memory/IO port
// Port B is fenced out of the IO region (address bit 12 set); rejected accesses still complete.
module dmio_arbiter #(
  parameter int AW = 64,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  output logic          ack_a,
  output logic [DW-1:0] rdata_a,
  input  logic          req_b,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  output logic          ack_b,
  output logic [DW-1:0] rdata_b,
  output logic          err_b,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  localparam int IO_BIT = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic last_b;
  logic owner_b;
  logic reject;
  logic grant;
  logic grant_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // On a tie the port that did not win last time is served.
  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    grant_b  = 1'b0;
    case (state)
      IDLE: begin
        if (req_a || req_b) begin
          grant    = 1'b1;
          grant_b  = req_b && (!req_a || !last_b);
          state_nx = ISSUE;
        end
      end
      ISSUE:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // mem_addr/mem_wdata double as the request latch; mem_we is high only during ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_b    <= 1'b1;
      owner_b   <= 1'b0;
      reject    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      ack_a     <= 1'b0;
      ack_b     <= 1'b0;
      err_b     <= 1'b0;
      rdata_a   <= '0;
      rdata_b   <= '0;
    end else begin
      mem_we <= 1'b0;
      ack_a  <= 1'b0;
      ack_b  <= 1'b0;
      err_b  <= 1'b0;

      if (grant) begin
        owner_b <= grant_b;
        last_b  <= grant_b;
        if (grant_b) begin
          mem_addr  <= addr_b;
          mem_wdata <= wdata_b;
          reject    <= addr_b[IO_BIT];
          mem_we    <= we_b && !addr_b[IO_BIT];
        end else begin
          mem_addr  <= addr_a;
          mem_wdata <= wdata_a;
          reject    <= 1'b0;
          mem_we    <= we_a;
        end
      end

      if (state == ISSUE) begin
        if (owner_b) begin
          ack_b   <= 1'b1;
          err_b   <= reject;
          rdata_b <= reject ? '0 : mem_rdata;
        end else begin
          ack_a   <= 1'b1;
          rdata_a <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmio_arbiter.sv
// tb/tb_dmio_arbiter.sv - scoreboard bench for dmio_arbiter with a RAM/LED model
// Drivers queue expected acks; a negedge monitor pops and compares them.
module tb_dmio_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] wdata_a = '0, wdata_b = '0;
  logic          ack_a, ack_b, err_b, mem_we;
  logic [DW-1:0] rdata_a, rdata_b, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  dmio_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .ack_a(ack_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .ack_b(ack_b), .rdata_b(rdata_b), .err_b(err_b),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int we_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] ram [0:4095];
  logic [63:0] led = '0;
  assign mem_rdata = mem_addr[12] ? led : ram[mem_addr[11:0]];
  always @(posedge clk) begin
    if (mem_we) begin
      we_cnt <= we_cnt + 1;
      if (mem_addr[12]) led <= mem_wdata;
      else ram[mem_addr[11:0]] <= mem_wdata;
    end
  end

  typedef struct {
    logic [63:0] rd;
    bit          chk_rd;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ack_a && ack_b) begin
        checks++;
        failures++;
        $display("FAIL ack_exclusive actual=both required=one");
      end
      if (ack_a) begin
        if (qa.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack_a actual=1 required=0");
        end else begin
          ea = qa.pop_front();
          if (ea.chk_rd) chk("rdata_a", rdata_a, ea.rd);
          if (ea.cyc >= 0) chk("ack_a_cycle", 64'(cyc), 64'(ea.cyc));
        end
      end
      if (ack_b) begin
        if (qb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack_b actual=1 required=0");
        end else begin
          eb = qb.pop_front();
          chk("err_b", 64'(err_b), 64'(eb.err));
          if (eb.chk_rd) chk("rdata_b", rdata_b, eb.rd);
          if (eb.cyc >= 0) chk("ack_b_cycle", 64'(cyc), 64'(eb.cyc));
        end
      end
    end
  end

  task automatic acc_a(input logic we, input logic [63:0] addr, input logic [63:0] wd,
                       input logic [63:0] rd, input bit chk_rd, input int off);
    int n;
    int ec;
    exp_t e;
    @(negedge clk);
    req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wd;
    ec = (off < 0) ? -1 : cyc + off;
    e = '{rd: rd, chk_rd: chk_rd, err: 1'b0, cyc: ec};
    qa.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack_a && n < 40);
    if (!ack_a) begin
      checks++;
      failures++;
      $display("FAIL timeout_a actual=no_ack required=ack");
    end
    req_a = 1'b0;
  endtask

  task automatic acc_b(input logic we, input logic [63:0] addr, input logic [63:0] wd,
                       input logic [63:0] rd, input bit chk_rd, input bit err, input int off);
    int n;
    int ec;
    exp_t e;
    @(negedge clk);
    req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wd;
    ec = (off < 0) ? -1 : cyc + off;
    e = '{rd: rd, chk_rd: chk_rd, err: err, cyc: ec};
    qb.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack_b && n < 40);
    if (!ack_b) begin
      checks++;
      failures++;
      $display("FAIL timeout_b actual=no_ack required=ack");
    end
    req_b = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    repeat (3) @(negedge clk);
    chk("rst_ack_a", 64'(ack_a), 64'd0);
    chk("rst_ack_b", 64'(ack_b), 64'd0);
    chk("rst_err_b", 64'(err_b), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_rdata_a", rdata_a, 64'd0);
    chk("rst_rdata_b", rdata_b, 64'd0);
    rst = 1'b0;

    acc_a(1'b1, 64'h10, 64'h1234, 64'h0, 1'b0, -1);
    acc_a(1'b1, 64'h5, 64'h77, 64'h0, 1'b0, -1);
    acc_a(1'b0, 64'h10, 64'h0, 64'h1234, 1'b1, 2);
    @(negedge clk);
    chk("ack_a_one_cycle", 64'(ack_a), 64'd0);

    // Abort a write while it sits in ISSUE.
    @(negedge clk);
    req_a = 1'b1; we_a = 1'b1; addr_a = 64'h5; wdata_a = 64'hAA;
    @(posedge clk);
    #1;
    chk("issue_mem_we", 64'(mem_we), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_mem_we", 64'(mem_we), 64'd0);
    chk("rst_async_mem_addr", mem_addr, 64'd0);
    chk("rst_async_rdata_a", rdata_a, 64'd0);
    req_a = 1'b0; we_a = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    fork
      begin
        acc_a(1'b0, 64'h5, 64'h0, 64'h77, 1'b1, 2);
        acc_a(1'b0, 64'h5, 64'h0, 64'h77, 1'b1, 5);
      end
      begin
        acc_b(1'b0, 64'h10, 64'h0, 64'h1234, 1'b1, 1'b0, 5);
        acc_b(1'b0, 64'h10, 64'h0, 64'h1234, 1'b1, 1'b0, 5);
      end
    join

    n0 = we_cnt;
    acc_b(1'b1, 64'h1000, 64'hFF, 64'h0, 1'b1, 1'b1, 2);
    chk("b_io_no_write", 64'(we_cnt - n0), 64'd0);
    chk("led_after_b", led, 64'h0);
    acc_a(1'b1, 64'h1000, 64'h5A, 64'h0, 1'b0, -1);
    chk("led_after_a", led, 64'h5A);
    acc_a(1'b0, 64'h1000, 64'h0, 64'h5A, 1'b1, 2);
    acc_b(1'b0, 64'h1000, 64'h0, 64'h0, 1'b1, 1'b1, 2);

    n0 = we_cnt;
    for (int i = 0; i < 4; i++) acc_b(1'b1, 64'(i), 64'(i + 1), 64'h0, 1'b0, 1'b0, 2);
    chk("burst_writes", 64'(we_cnt - n0), 64'd4);
    for (int i = 0; i < 4; i++) acc_a(1'b0, 64'(i), 64'h0, 64'(i + 1), 1'b1, 2);

    repeat (4) @(negedge clk);
    chk("qa_drained", 64'(qa.size()), 64'd0);
    chk("qb_drained", 64'(qb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
